fifo_burst_reader: RTL and testbench
====================================

// Module: fifo_burst_reader
// PURPOSE
// Read-side master for the show-ahead FIFO (data_out = head entry, pop on rd_en).
// On a start command it pops exactly burst_len+1 words from the FIFO. It presents them
// downstream on an AXI-style valid/ready channel with last, for example a W or R
// channel in the crossbar.
// A 2-entry output skid buffer keeps m_ready off the combinational path to fifo_rd_en.
// PARAMETERS
// DATA_WIDTH  32  width of fifo_data / m_data
// LEN_WIDTH   8   width of burst_len (AXI LEN encoding: beats-1)
// PORTS
// clk           in   1           clock, all logic on posedge
// rst_n         in   1           asynchronous active-low reset
// start         in   1           begin a burst; sampled only in IDLE
// burst_len     in   LEN_WIDTH   beats-1; captured when start is accepted
// busy          out  1           high from start acceptance until done pulse inclusive
// done          out  1           one-cycle pulse after final beat handshake
// fifo_rd_en    out  1           pop request to FIFO
// fifo_data     in   DATA_WIDTH  FIFO head word (valid while !fifo_empty)
// fifo_empty    in   1           FIFO empty flag
// m_valid       out  1           downstream beat valid
// m_ready       in   1           downstream ready
// m_data        out  DATA_WIDTH  downstream beat data
// m_last        out  1           final beat of burst
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, buffer empty, counters=0.
//   All outputs are 0: busy, done, fifo_rd_en, m_valid, m_data, m_last.
// - FSM states:
//   IDLE:  start=1 -> READ; latch pops_left=burst_len+1 (LEN_WIDTH+1 bits), beat_idx=0.
//   READ:  pops are issued; when the final pop occurs (pops_left==1 && fifo_rd_en) -> DRAIN.
//   DRAIN: no pops; when the handshake with m_last=1 occurs -> DONE.
//   DONE:  done=1 for one cycle -> IDLE. A start during DONE is ignored.
// - start is ignored in READ/DRAIN/DONE. burst_len is a don't-care outside acceptance.
// - fifo_rd_en = (state==READ) && !fifo_empty && pops_left!=0 && buf_cnt<2.
//   It is combinational from registered state and fifo_empty only; it never depends on m_ready.
// - On a posedge with fifo_rd_en=1, fifo_data is written into the skid buffer tail and
//   pops_left decrements.
// - Buffer count rule: buf_cnt_next = buf_cnt + pop - (m_valid && m_ready), range 0..2.
//   A push and a pop in the same cycle are both legal.
// - m_valid = buf_cnt!=0; m_data/m_last show the buffer head. FIFO order is preserved.
// - Once m_valid rises, m_valid/m_data/m_last stay stable until m_ready=1.
// - m_last=1 on the beat whose index equals the captured burst_len; beat_idx increments
//   per handshake. burst_len=0 gives a single beat with m_last=1.
// - Latency: start accepted at edge N, fifo_rd_en high in cycle N+1 (if non-empty),
//   first m_valid in cycle N+2.
// - Throughput: with m_ready held high and the FIFO non-empty, one beat per cycle
//   (buf_cnt settles at 1).
// - FIFO empty mid-burst: fifo_rd_en=0 and m_valid drops once the buffer drains.
//   The burst resumes when fifo_empty=0. There is no timeout.
// - The reader never pops when fifo_empty=1, so it never causes FIFO underflow.
// - busy=1 in READ, DRAIN and DONE; done asserts only in DONE.
// - Reset mid-burst: buffered beats are discarded and popped words are lost;
//   the block returns to IDLE.
// TESTING
// T1 single beat: FIFO {0xA5}, start with burst_len=0 -> one beat 0xA5 with m_last=1;
//    done 1 cycle after the handshake; busy falls after done.
// T2 full rate: FIFO 0x10..0x17, burst_len=7, m_ready=1 -> 8 consecutive beats
//    0x10..0x17; m_last only on 0x17; first m_valid 2 cycles after start.
// T3 backpressure: burst_len=3, m_ready toggles 1,0,0,1,... -> data stable while stalled;
//    fifo_rd_en never high while buf_cnt==2; exactly 4 pops in total.
// T4 starvation: FIFO holds 2 of 4 words, burst_len=3 -> 2 beats, m_valid low and
//    busy high; push 2 more words -> remaining beats, m_last on 4th, done.
// T5 start while busy: assert start during READ with burst_len=9 -> ignored; the
//    original burst completes with its own length; next start in IDLE is accepted.
// T6 reset mid-burst: deassert rst_n during DRAIN -> all outputs 0 immediately
//    (asynchronous); after release, state IDLE with m_valid=0.

Source files
------------

// File: rtl/fifo_burst_reader_if.sv
// ----------------------------------------------------------------------------
// fifo_burst_reader_if
// Bundles the command, FIFO read-side and downstream valid/ready channel of
// the burst reader so they travel as one port.
//
// Signals
//   start       command : begin a burst (sampled by the reader only when idle)
//   burst_len   command : beats-1 of the burst, captured with start
//   busy        status  : burst in progress, through the done pulse
//   done        status  : one-cycle pulse after the final beat handshake
//   fifo_rd_en  FIFO    : pop request to a show-ahead FIFO
//   fifo_data   FIFO    : FIFO head word
//   fifo_empty  FIFO    : FIFO empty flag
//   m_valid     stream  : beat valid
//   m_ready     stream  : downstream ready
//   m_data      stream  : beat data
//   m_last      stream  : final beat of the burst
//
// Modports
//   master : the burst reader itself
//   slave  : the environment (command source, FIFO and downstream sink)
// ----------------------------------------------------------------------------
interface fifo_burst_reader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
);

   logic                  start;
   logic [LEN_WIDTH-1:0]  burst_len;
   logic                  busy;
   logic                  done;

   logic                  fifo_rd_en;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_empty;

   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;

   modport master (
      input  start,
      input  burst_len,
      output busy,
      output done,
      output fifo_rd_en,
      input  fifo_data,
      input  fifo_empty,
      output m_valid,
      input  m_ready,
      output m_data,
      output m_last
   );

   modport slave (
      output start,
      output burst_len,
      input  busy,
      input  done,
      input  fifo_rd_en,
      output fifo_data,
      output fifo_empty,
      input  m_valid,
      output m_ready,
      input  m_data,
      input  m_last
   );

endinterface

// File: rtl/fifo_burst_reader.sv
// ----------------------------------------------------------------------------
// fifo_burst_reader
// Read-side master for a show-ahead FIFO. A start command pops exactly
// burst_len+1 words and presents them downstream on a valid/ready channel
// with last. A 2-entry skid buffer sits between the FIFO and the output so
// that m_ready never reaches fifo_rd_en combinationally: the pop decision only
// looks at registered state and fifo_empty.
//
// Ports
//   clk    in  clock, all logic on the rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    fifo_burst_reader_if.master
//            command  : start, burst_len -> busy, done
//            FIFO     : fifo_rd_en -> fifo_data, fifo_empty
//            stream   : m_valid, m_data, m_last -> m_ready
//
// Parameters
//   DATA_WIDTH  width of fifo_data / m_data
//   LEN_WIDTH   width of burst_len (beats-1 encoding)
// ----------------------------------------------------------------------------
module fifo_burst_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fifo_burst_reader_if.master  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [LEN_WIDTH:0] POPS_ONE = (LEN_WIDTH+1)'(1);
   localparam logic [1:0]         BUF_FULL = 2'd2;

   // Control state
   state_t                state_q;
   logic [LEN_WIDTH:0]    pops_left_q;   // words still to pop (up to 2^LEN_WIDTH)
   logic [LEN_WIDTH-1:0]  len_q;         // captured burst_len, index of the last beat
   logic [LEN_WIDTH-1:0]  beat_idx_q;    // index of the beat at the buffer head
   logic                  busy_q;
   logic                  done_q;

   // Skid buffer: entry 0 is always the head when buf_cnt_q != 0
   logic [1:0]            buf_cnt_q, buf_cnt_d;
   logic [DATA_WIDTH-1:0] buf0_q,    buf0_d;
   logic [DATA_WIDTH-1:0] buf1_q,    buf1_d;

   logic                  pop;           // FIFO pop this cycle
   logic                  beat_hs;       // downstream handshake this cycle
   logic                  head_last;     // head beat is the final one

   // The pop only looks at registered state and the FIFO flag; the buffer
   // always has a free slot when buf_cnt_q < 2, whatever m_ready does.
   assign pop       = (state_q == S_READ) && !bus.fifo_empty &&
                      (pops_left_q != '0) && (buf_cnt_q != BUF_FULL);
   assign beat_hs   = (buf_cnt_q != 2'd0) && bus.m_ready;
   assign head_last = (buf_cnt_q != 2'd0) && (beat_idx_q == len_q);

   assign bus.fifo_rd_en = pop;
   assign bus.m_valid    = (buf_cnt_q != 2'd0);
   assign bus.m_data     = buf0_q;
   assign bus.m_last     = head_last;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

   // ------------------------------------------------------------------------
   // Skid buffer next state. Push goes to the first free slot; a handshake
   // shifts entry 1 down to the head. With one entry, a simultaneous push and
   // handshake replaces the head directly. A push while full cannot happen
   // because pop is gated by buf_cnt_q.
   // ------------------------------------------------------------------------
   always_comb begin
      buf_cnt_d = buf_cnt_q;
      buf0_d    = buf0_q;
      buf1_d    = buf1_q;
      unique case ({pop, beat_hs})
         2'b10: begin
            if (buf_cnt_q == 2'd0) begin
               buf0_d = bus.fifo_data;
            end else begin
               buf1_d = bus.fifo_data;
            end
            buf_cnt_d = buf_cnt_q + 2'd1;
         end
         2'b01: begin
            buf0_d    = buf1_q;
            buf_cnt_d = buf_cnt_q - 2'd1;
         end
         2'b11: begin
            if (buf_cnt_q == 2'd1) begin
               buf0_d = bus.fifo_data;
            end else begin
               buf0_d = buf1_q;
               buf1_d = bus.fifo_data;
            end
         end
         default: begin
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Burst FSM with registered busy/done, plus the skid buffer registers.
   // Data registers are reset too so m_data reads 0 out of reset.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pops_left_q <= '0;
         len_q       <= '0;
         beat_idx_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         buf_cnt_q   <= 2'd0;
         buf0_q      <= '0;
         buf1_q      <= '0;
      end else begin
         buf_cnt_q <= buf_cnt_d;
         buf0_q    <= buf0_d;
         buf1_q    <= buf1_d;

         if (beat_hs) begin
            beat_idx_q <= beat_idx_q + 1'b1;
         end

         unique case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  state_q     <= S_READ;
                  pops_left_q <= (LEN_WIDTH+1)'(bus.burst_len) + POPS_ONE;
                  len_q       <= bus.burst_len;
                  beat_idx_q  <= '0;
                  busy_q      <= 1'b1;
               end
            end

            S_READ: begin
               if (pop) begin
                  pops_left_q <= pops_left_q - POPS_ONE;
                  if (pops_left_q == POPS_ONE) begin
                     state_q <= S_DRAIN;
                  end
               end
            end

            // The last word entered the buffer no earlier than the READ->DRAIN
            // edge, so the final handshake is always seen here.
            S_DRAIN: begin
               if (beat_hs && head_last) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

   localparam int DW = 32;
   localparam int LW = 8;

   logic clk;
   logic rst_n;

   fifo_burst_reader_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

   fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Show-ahead FIFO model
   logic [DW-1:0] mem [0:63];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign bus.fifo_empty = (wr_ptr == rd_ptr);
   assign bus.fifo_data  = mem[rd_ptr[5:0]];

   int ncmp = 0;
   int nerr = 0;
   int cyc  = 0;

   // Monitor state (written only by the negedge monitor)
   logic          pop_n = 1'b0;
   int            outstanding = 0;
   int            npops = 0;
   int            nbeats = 0;
   int            done_cnt = 0;
   int            last_done_cyc = 0;
   logic          done_busy = 1'b0;
   logic          stall_q = 1'b0;
   logic [DW-1:0] stall_data = '0;
   logic          stall_last = 1'b0;
   logic [DW-1:0] beat_data [0:63];
   logic          beat_last [0:63];
   int            beat_cyc  [0:63];

   int start_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && pop_n) rd_ptr <= rd_ptr + 1;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         pop_n       = 1'b0;
         outstanding = 0;
         stall_q     = 1'b0;
      end else begin
         if (bus.fifo_rd_en) begin
            chk("no_underflow", bus.fifo_empty, 1'b0);
            chk("no_pop_when_buf_full", (outstanding >= 2), 1'b0);
         end
         if (stall_q) begin
            chk("stall_valid", bus.m_valid, 1'b1);
            chk("stall_data", bus.m_data, stall_data);
            chk("stall_last", bus.m_last, stall_last);
         end
         stall_q    = bus.m_valid && !bus.m_ready;
         stall_data = bus.m_data;
         stall_last = bus.m_last;
         pop_n      = bus.fifo_rd_en;
         if (bus.fifo_rd_en) begin
            npops++;
            outstanding++;
         end
         if (bus.m_valid && bus.m_ready) begin
            beat_data[nbeats] = bus.m_data;
            beat_last[nbeats] = bus.m_last;
            beat_cyc[nbeats]  = cyc;
            nbeats++;
            outstanding--;
         end
         if (bus.done) begin
            done_cnt++;
            last_done_cyc = cyc;
            done_busy     = bus.busy;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] w);
      mem[wr_ptr[5:0]] = w;
      wr_ptr++;
   endtask

   task automatic start_burst(input logic [LW-1:0] len);
      bus.start     = 1'b1;
      bus.burst_len = len;
      step();
      start_cyc     = cyc;
      bus.start     = 1'b0;
      bus.burst_len = 8'h55;
   endtask

   task automatic wait_done(input int budget);
      int d0 = done_cnt;
      int i  = 0;
      while (done_cnt == d0 && i < budget) begin
         step();
         i++;
      end
      chk("done_within_budget", (done_cnt != d0), 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      int p;
      int d;
      logic [3:0] pat;

      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.burst_len = '0;
      bus.m_ready   = 1'b0;
      #1;
      // reset state
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_rd_en", bus.fifo_rd_en, 1'b0);
      chk("rst_m_valid", bus.m_valid, 1'b0);
      chk("rst_m_data", bus.m_data, 32'h0);
      chk("rst_m_last", bus.m_last, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      step();

      // T1 single beat
      push(32'hA5);
      bus.m_ready = 1'b1;
      b = nbeats; p = npops; d = done_cnt;
      start_burst(8'd0);
      wait_done(20);
      chk("t1_beats", nbeats - b, 1);
      chk("t1_data", beat_data[b], 32'hA5);
      chk("t1_last", beat_last[b], 1'b1);
      chk("t1_done_after_hs", last_done_cyc - beat_cyc[b], 1);
      chk("t1_busy_during_done", done_busy, 1'b1);
      chk("t1_busy_after", bus.busy, 1'b0);
      chk("t1_done_pulse_low", bus.done, 1'b0);
      chk("t1_pops", npops - p, 1);
      step();
      chk("t1_done_one_cycle", done_cnt - d, 1);

      // T2 full rate
      for (int i = 0; i < 8; i++) push(32'h10 + i);
      b = nbeats; p = npops;
      start_burst(8'd7);
      chk("t2_rd_en_n1", bus.fifo_rd_en, 1'b1);
      chk("t2_valid_n1", bus.m_valid, 1'b0);
      step();
      chk("t2_valid_n2", bus.m_valid, 1'b1);
      wait_done(40);
      chk("t2_beats", nbeats - b, 8);
      for (int i = 0; i < 8; i++) begin
         chk("t2_data", beat_data[b+i], 32'h10 + i);
         chk("t2_last", beat_last[b+i], (i == 7));
         chk("t2_back_to_back", beat_cyc[b+i] - beat_cyc[b], i);
      end
      chk("t2_first_beat_cycle", beat_cyc[b] - start_cyc, 1);
      chk("t2_pops", npops - p, 8);

      // T3 backpressure, m_ready 1,0,0,1 repeating
      for (int i = 0; i < 4; i++) push(32'h30 + i);
      b = nbeats; p = npops; d = done_cnt;
      pat = 4'b1001;
      bus.m_ready = 1'b0;
      start_burst(8'd3);
      for (int i = 0; i < 40; i++) begin
         bus.m_ready = pat[i % 4];
         step();
      end
      bus.m_ready = 1'b1;
      chk("t3_done", done_cnt - d, 1);
      chk("t3_beats", nbeats - b, 4);
      for (int i = 0; i < 4; i++) begin
         chk("t3_data", beat_data[b+i], 32'h30 + i);
         chk("t3_last", beat_last[b+i], (i == 3));
      end
      chk("t3_pops", npops - p, 4);

      // T4 starvation
      push(32'h40);
      push(32'h41);
      b = nbeats;
      start_burst(8'd3);
      repeat (10) step();
      chk("t4_partial_beats", nbeats - b, 2);
      chk("t4_starved_valid", bus.m_valid, 1'b0);
      chk("t4_starved_busy", bus.busy, 1'b1);
      chk("t4_starved_rd_en", bus.fifo_rd_en, 1'b0);
      push(32'h42);
      push(32'h43);
      wait_done(20);
      chk("t4_beats", nbeats - b, 4);
      for (int i = 0; i < 4; i++) begin
         chk("t4_data", beat_data[b+i], 32'h40 + i);
         chk("t4_last", beat_last[b+i], (i == 3));
      end

      // T5 start while busy
      for (int i = 0; i < 3; i++) push(32'h50 + i);
      push(32'h60);
      push(32'h61);
      bus.m_ready = 1'b0;
      b = nbeats; p = npops;
      start_burst(8'd2);
      bus.start     = 1'b1;
      bus.burst_len = 8'd9;
      step();
      bus.start     = 1'b0;
      repeat (3) step();
      bus.m_ready = 1'b1;
      wait_done(30);
      chk("t5_beats", nbeats - b, 3);
      for (int i = 0; i < 3; i++) begin
         chk("t5_data", beat_data[b+i], 32'h50 + i);
         chk("t5_last", beat_last[b+i], (i == 2));
      end
      chk("t5_pops", npops - p, 3);
      repeat (5) step();
      chk("t5_idle_busy", bus.busy, 1'b0);
      chk("t5_idle_no_pops", npops - p, 3);
      b = nbeats;
      start_burst(8'd1);
      wait_done(20);
      chk("t5_next_beats", nbeats - b, 2);
      chk("t5_next_data0", beat_data[b], 32'h60);
      chk("t5_next_data1", beat_data[b+1], 32'h61);
      chk("t5_next_last", beat_last[b+1], 1'b1);

      // T6 reset mid-burst (DRAIN with a full buffer)
      for (int i = 0; i < 4; i++) push(32'h70 + i);
      bus.m_ready = 1'b0;
      start_burst(8'd1);
      repeat (4) step();
      chk("t6_pre_valid", bus.m_valid, 1'b1);
      chk("t6_pre_busy", bus.busy, 1'b1);
      chk("t6_pre_data", bus.m_data, 32'h70);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", bus.busy, 1'b0);
      chk("t6_rst_done", bus.done, 1'b0);
      chk("t6_rst_rd_en", bus.fifo_rd_en, 1'b0);
      chk("t6_rst_valid", bus.m_valid, 1'b0);
      chk("t6_rst_data", bus.m_data, 32'h0);
      chk("t6_rst_last", bus.m_last, 1'b0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      step();
      step();
      chk("t6_post_busy", bus.busy, 1'b0);
      chk("t6_post_valid", bus.m_valid, 1'b0);
      chk("t6_post_rd_en", bus.fifo_rd_en, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
